// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop stage with preset/prereset. Each
// command is expanded into N drive cycles. q is modelled and checked once per command.
module jk_cmd_sequencer #(
  parameter int   CNT_W  = 4,
  parameter logic INIT_Q = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_force,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  output logic             J,
  output logic             K,
  output logic             preset,
  output logic             prereset,
  input  logic             q_in,
  output logic             q_exp,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_SET = 2'b01, OP_CLEAR = 2'b10, OP_TOGGLE = 2'b11} op_t;

  state_t           state, state_nx;
  op_t              op_q, op_nx;
  logic             force_q, force_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             q_exp_nx, err_nx;
  logic             j_nx, k_nx, preset_nx, prereset_nx;
  logic             accept;

  assign accept = cmd_valid && cmd_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    force_nx = force_q;
    cnt_nx   = cnt_q;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_RUN;
          op_nx    = op_t'(cmd_op);
          force_nx = cmd_force;
          cnt_nx   = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
        end
      end
      S_RUN: begin
        // The counter holds the drive cycles still to go, including this one.
        if (cnt_q == CNT_W'(1)) state_nx = S_DONE;
        else                    cnt_nx   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // Drive outputs are registered, so decode them from the state being entered.
    j_nx        = 1'b0;
    k_nx        = 1'b0;
    preset_nx   = 1'b0;
    prereset_nx = 1'b0;
    if (state_nx == S_RUN) begin
      unique case (op_nx)
        OP_SET:    if (force_nx) preset_nx   = 1'b1; else j_nx = 1'b1;
        OP_CLEAR:  if (force_nx) prereset_nx = 1'b1; else k_nx = 1'b1;
        OP_TOGGLE: begin
          j_nx = 1'b1;
          k_nx = 1'b1;
        end
        default: ;
      endcase
    end

    // The modelled q follows the flip-flop, which samples the drive on each RUN edge.
    q_exp_nx = q_exp;
    if (state == S_RUN) begin
      unique case (op_q)
        OP_SET:    q_exp_nx = 1'b1;
        OP_CLEAR:  q_exp_nx = 1'b0;
        OP_TOGGLE: q_exp_nx = ~q_exp;
        default:   q_exp_nx = q_exp;
      endcase
    end

    // A mismatch in DONE takes priority over a simultaneous clear.
    err_nx = err;
    if (state == S_DONE && q_in != q_exp) err_nx = 1'b1;
    else if (err_clr)                     err_nx = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= OP_HOLD;
      force_q   <= 1'b0;
      cnt_q     <= '0;
      q_exp     <= INIT_Q;
      err       <= 1'b0;
      J         <= 1'b0;
      K         <= 1'b0;
      preset    <= 1'b0;
      prereset  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      op_q      <= op_nx;
      force_q   <= force_nx;
      cnt_q     <= cnt_nx;
      q_exp     <= q_exp_nx;
      err       <= err_nx;
      J         <= j_nx;
      K         <= k_nx;
      preset    <= preset_nx;
      prereset  <= prereset_nx;
      done      <= (state_nx == S_DONE);
      busy      <= (state_nx != S_IDLE);
      cmd_ready <= (state_nx == S_IDLE);
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flip-flop on the
// drive outputs; q_in can be tied low to provoke mismatches.
module tb_jk_cmd_sequencer;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_force = 1'b0;
  logic [3:0] cmd_count = 4'd0;
  logic       err_clr = 1'b0;
  logic       tie_q0 = 1'b0;
  logic       cmd_ready, J, K, preset, prereset, q_in, q_exp, busy, done, err;
  logic       q_ff;
  logic [3:0] drv;
  logic [2:0] ctl;

  int n_vec = 0;
  int n_bad = 0;

  jk_cmd_sequencer #(.CNT_W(4), .INIT_Q(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_force(cmd_force), .cmd_count(cmd_count), .cmd_ready(cmd_ready),
    .J(J), .K(K), .preset(preset), .prereset(prereset), .q_in(q_in),
    .q_exp(q_exp), .busy(busy), .done(done), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Flip-flop being driven: preset over prereset over J/K.
  always @(posedge clk) begin
    if (!reset_n)      q_ff <= 1'b0;
    else if (preset)   q_ff <= 1'b1;
    else if (prereset) q_ff <= 1'b0;
    else case ({J, K})
      2'b10:   q_ff <= 1'b1;
      2'b01:   q_ff <= 1'b0;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end

  assign q_in = tie_q0 ? 1'b0 : q_ff;
  assign drv  = {J, K, preset, prereset};
  assign ctl  = {busy, cmd_ready, done};

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  // Presents one command; returns at the first negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic frc, input logic [3:0] cnt);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_force = frc; cmd_count = cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++; if (drv !== 4'b0000) begin n_bad++; $display("FAIL reset_drv: got %b want 0000", drv); end
    n_vec++; if (ctl !== 3'b010) begin n_bad++; $display("FAIL reset_ctl: got %b want 010", ctl); end
    n_vec++; if ({q_exp, err} !== 2'b00) begin n_bad++; $display("FAIL reset_q_err: got %b want 00", {q_exp, err}); end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({drv, ctl} !== 7'b0000010) begin n_bad++; $display("FAIL idle_after_reset: got %b want 0000010", {drv, ctl}); end
  endtask

  task automatic test_set;
    issue(OP_SET, 1'b0, 4'd1);
    n_vec++; if ({drv, ctl} !== 7'b1000100) begin n_bad++; $display("FAIL set_drive: got %b want 1000100", {drv, ctl}); end
    @(negedge clk);
    n_vec++; if ({drv, ctl} !== 7'b0000101) begin n_bad++; $display("FAIL set_done: got %b want 0000101", {drv, ctl}); end
    n_vec++; if (q_exp !== 1'b1) begin n_bad++; $display("FAIL set_q_exp: got %b want 1", q_exp); end
    @(negedge clk);
    n_vec++; if ({ctl, err} !== 4'b0100) begin n_bad++; $display("FAIL set_end: got %b want 0100", {ctl, err}); end
  endtask

  task automatic test_clear_force;
    issue(OP_CLEAR, 1'b1, 4'd0);
    n_vec++; if ({drv, ctl} !== 7'b0001100) begin n_bad++; $display("FAIL clrf_drive: got %b want 0001100", {drv, ctl}); end
    cmd_valid = 1'b1; cmd_op = OP_SET; cmd_force = 1'b0; cmd_count = 4'd5;
    @(negedge clk);
    n_vec++; if ({drv, ctl} !== 7'b0000101) begin n_bad++; $display("FAIL clrf_done: got %b want 0000101", {drv, ctl}); end
    n_vec++; if (q_exp !== 1'b0) begin n_bad++; $display("FAIL clrf_q_exp: got %b want 0", q_exp); end
    @(negedge clk);
    n_vec++; if (ctl !== 3'b010) begin n_bad++; $display("FAIL clrf_ready: got %b want 010", ctl); end
    cmd_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({drv, ctl, q_exp} !== 8'b00000100) begin n_bad++; $display("FAIL clrf_ignored: got %b want 00000100", {drv, ctl, q_exp}); end
  endtask

  task automatic test_toggle;
    issue(OP_TOGGLE, 1'b0, 4'd3);
    for (int m = 1; m <= 3; m++) begin
      n_vec++; if ({drv, ctl} !== 7'b1100100) begin n_bad++; $display("FAIL tog_drive%0d: got %b want 1100100", m, {drv, ctl}); end
      n_vec++; if (q_exp !== (m == 2)) begin n_bad++; $display("FAIL tog_q%0d: got %b want %b", m, q_exp, (m == 2)); end
      @(negedge clk);
    end
    n_vec++; if ({drv, ctl, q_exp} !== 8'b00001011) begin n_bad++; $display("FAIL tog_done: got %b want 00001011", {drv, ctl, q_exp}); end
    @(negedge clk);
    n_vec++; if ({ctl, err} !== 4'b0100) begin n_bad++; $display("FAIL tog_ready5: got %b want 0100", {ctl, err}); end
  endtask

  task automatic test_hold_max;
    int runs;
    runs = 0;
    issue(OP_HOLD, 1'b0, 4'd15);
    for (int m = 1; m <= 15; m++) begin
      if ({drv, ctl} === 7'b0000100) runs++;
      @(negedge clk);
    end
    n_vec++; if (runs !== 15) begin n_bad++; $display("FAIL hold_run_cycles: got %0d want 15", runs); end
    n_vec++; if ({ctl, q_exp} !== 4'b1011) begin n_bad++; $display("FAIL hold_done16: got %b want 1011", {ctl, q_exp}); end
    @(negedge clk);
    n_vec++; if (ctl !== 3'b010) begin n_bad++; $display("FAIL hold_ready17: got %b want 010", ctl); end
  endtask

  task automatic test_mismatch;
    tie_q0 = 1'b1;
    issue(OP_SET, 1'b0, 4'd2);
    repeat (2) @(negedge clk);
    n_vec++; if ({ctl, err} !== 4'b1010) begin n_bad++; $display("FAIL mm_done: got %b want 1010", {ctl, err}); end
    @(negedge clk);
    n_vec++; if ({ctl, err} !== 4'b0101) begin n_bad++; $display("FAIL mm_err_set: got %b want 0101", {ctl, err}); end
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL mm_sticky: got %b want 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL mm_clear: got %b want 0", err); end
    issue(OP_SET, 1'b0, 4'd1);
    @(negedge clk);
    n_vec++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL mm_clr_done: got %b want 10", {done, err}); end
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL mm_set_wins: got %b want 1", err); end
    err_clr = 1'b0;
    tie_q0  = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL mm_final_clear: got %b want 0", err); end
  endtask

  task automatic test_back_to_back;
    issue(OP_CLEAR, 1'b0, 4'd2);
    n_vec++; if ({drv, ctl} !== 7'b0100100) begin n_bad++; $display("FAIL b2b_clear: got %b want 0100100", {drv, ctl}); end
    repeat (2) @(negedge clk);
    n_vec++; if (ctl !== 3'b101) begin n_bad++; $display("FAIL b2b_done1: got %b want 101", ctl); end
    cmd_valid = 1'b1; cmd_op = OP_TOGGLE; cmd_force = 1'b0; cmd_count = 4'd1;
    @(negedge clk);
    n_vec++; if ({ctl, q_exp} !== 4'b0100) begin n_bad++; $display("FAIL b2b_ready: got %b want 0100", {ctl, q_exp}); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++; if ({drv, ctl} !== 7'b1100100) begin n_bad++; $display("FAIL b2b_toggle: got %b want 1100100", {drv, ctl}); end
    @(negedge clk);
    n_vec++; if ({ctl, q_exp, err} !== 5'b10110) begin n_bad++; $display("FAIL b2b_done2: got %b want 10110", {ctl, q_exp, err}); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int dones;
    dones = 0;
    issue(OP_TOGGLE, 1'b0, 4'd15);
    repeat (3) @(negedge clk);
    n_vec++; if ({drv, ctl} !== 7'b1100100) begin n_bad++; $display("FAIL mr_running: got %b want 1100100", {drv, ctl}); end
    reset_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({drv, ctl} !== 7'b0000010) begin n_bad++; $display("FAIL mr_abort: got %b want 0000010", {drv, ctl}); end
    n_vec++; if ({q_exp, err} !== 2'b00) begin n_bad++; $display("FAIL mr_q_exp: got %b want 00", {q_exp, err}); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || cmd_ready !== 1'b1) dones++;
    end
    n_vec++; if (dones !== 0) begin n_bad++; $display("FAIL mr_no_done: got %0d bad cycles want 0", dones); end
  endtask

  initial begin
    test_reset;
    test_set;
    test_clear_force;
    test_toggle;
    test_hold_max;
    test_mismatch;
    test_back_to_back;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
